// File: rtl/shifter_pkg.sv
// Shared types and constants for the multi-cycle right shifter.
package shifter_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} shift_state_t;

  localparam logic SHIFT_LOGICAL = 1'b0;
  localparam logic SHIFT_ARITH   = 1'b1;

endpackage

// File: rtl/configurable_mux.sv
// N-input one-hot-free selector; out-of-range selects yield zero.
module configurable_mux #(
  parameter int nb_bits_data = 32,
  parameter int nb_inputs    = 2,
  parameter int nb_bits_sel  = (nb_inputs > 1) ? $clog2(nb_inputs) : 1
) (
  input  logic [nb_bits_data-1:0] data_i [nb_inputs],
  input  logic [nb_bits_sel-1:0]  sel_i,
  output logic [nb_bits_data-1:0] data_o
);

  always_comb begin
    data_o = '0;
    for (int i = 0; i < nb_inputs; i++) begin
      if (sel_i == nb_bits_sel'(i)) data_o = data_i[i];
    end
  end

endmodule

// File: rtl/fixed_shifter_right.sv
// One constant-distance right-shift stage with bypass when not enabled.
module fixed_shifter_right
  import shifter_pkg::*;
#(
  parameter int nb_bits_data = 32,
  parameter int shift_value  = 1
) (
  input  logic [nb_bits_data-1:0] data_i,
  input  logic                    enable_i,
  input  logic                    arith_i,
  output logic [nb_bits_data-1:0] data_o
);

  logic [nb_bits_data-1:0] shifted;
  logic [nb_bits_data-1:0] choices [2];

  // Arithmetic fill copies the current MSB, which an arithmetic stage never changes.
  assign shifted = (arith_i == SHIFT_ARITH)
                   ? nb_bits_data'($signed(data_i) >>> shift_value)
                   : data_i >> shift_value;

  assign choices[0] = data_i;
  assign choices[1] = shifted;

  configurable_mux #(
    .nb_bits_data(nb_bits_data),
    .nb_inputs   (2)
  ) bypass_mux (
    .data_i(choices),
    .sel_i (enable_i),
    .data_o(data_o)
  );

endmodule

// File: rtl/sequential_shifter_right.sv
// Multi-cycle SRL/SRA: one power-of-two stage per cycle, fixed latency.
//   state | meaning
//   IDLE  | waiting for start_i, ready_o high
//   SHIFT | applying stage cnt_q to the working register
//   DONE  | result in data_o, valid_o pulse, may accept next start
module sequential_shifter_right
  import shifter_pkg::*;
#(
  parameter int nb_bits_data  = 32,
  parameter int nb_bits_shamt = $clog2(nb_bits_data)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [nb_bits_data-1:0]  data_i,
  input  logic [nb_bits_shamt-1:0] shamt_i,
  input  logic                     arith_i,
  output logic                     ready_o,
  output logic                     valid_o,
  output logic [nb_bits_data-1:0]  data_o
);

  localparam int nb_bits_cnt = (nb_bits_shamt > 1) ? $clog2(nb_bits_shamt) : 1;
  localparam logic [nb_bits_cnt-1:0] last_stage = nb_bits_cnt'(nb_bits_shamt - 1);

  shift_state_t state_q, state_d;
  logic [nb_bits_data-1:0]  work_q;
  logic [nb_bits_data-1:0]  result_q;
  logic [nb_bits_data-1:0]  stage_sel;
  logic [nb_bits_data-1:0]  stage_out [nb_bits_shamt];
  logic [nb_bits_shamt-1:0] shamt_q;
  logic                     arith_q;
  logic [nb_bits_cnt-1:0]   cnt_q;
  logic                     accept;

  for (genvar k = 0; k < nb_bits_shamt; k++) begin : g_stage
    fixed_shifter_right #(
      .nb_bits_data(nb_bits_data),
      .shift_value (1 << k)
    ) stage (
      .data_i  (work_q),
      .enable_i(shamt_q[k]),
      .arith_i (arith_q),
      .data_o  (stage_out[k])
    );
  end

  configurable_mux #(
    .nb_bits_data(nb_bits_data),
    .nb_inputs   (nb_bits_shamt),
    .nb_bits_sel (nb_bits_cnt)
  ) stage_mux (
    .data_i(stage_out),
    .sel_i (cnt_q),
    .data_o(stage_sel)
  );

  always_comb begin
    state_d = state_q;
    ready_o = 1'b0;
    valid_o = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (start_i) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == last_stage) state_d = DONE;
      end
      DONE: begin
        ready_o = 1'b1;
        valid_o = 1'b1;
        if (start_i) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      work_q   <= '0;
      result_q <= '0;
      shamt_q  <= '0;
      arith_q  <= SHIFT_LOGICAL;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        work_q  <= data_i;
        shamt_q <= shamt_i;
        arith_q <= arith_i;
        cnt_q   <= '0;
      end else if (state_q == SHIFT) begin
        work_q <= stage_sel;
        cnt_q  <= cnt_q + 1'b1;
        if (cnt_q == last_stage) result_q <= stage_sel;
      end
    end
  end

  assign data_o = result_q;

endmodule

// File: tb/tb_sequential_shifter_right.sv
// Self-checking bench for sequential_shifter_right: vector table, corner sequences, result scoreboard.
module tb_sequential_shifter_right;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] data_i = '0;
  logic [4:0]  shamt_i = '0;
  logic        arith_i = 1'b0;
  logic        ready_o;
  logic        valid_o;
  logic [31:0] data_o;

  int checks = 0;
  int fails  = 0;
  logic [31:0] exp_q [$];
  logic        prev_valid = 1'b0;

  sequential_shifter_right #(.nb_bits_data(32)) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start_i(start_i),
    .data_i (data_i),
    .shamt_i(shamt_i),
    .arith_i(arith_i),
    .ready_o(ready_o),
    .valid_o(valid_o),
    .data_o (data_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  shamt;
    logic        arith;
    logic [31:0] expected;
  } vec_t;

  function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] s, input logic a);
    logic [31:0] r;
    r = d;
    for (int i = 0; i < int'(s); i++) r = {a & r[31], r[31:1]};
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Scoreboard: every valid_o pulse must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (valid_o === 1'b1) begin
      checks++;
      if (prev_valid) begin
        fails++;
        $display("FAIL valid_back_to_back: got valid high two cycles, expected single pulse");
      end
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_valid: got valid with data %h, expected no result", data_o);
      end else begin
        check("result_data", data_o, exp_q.pop_front());
      end
    end
    prev_valid = (valid_o === 1'b1);
  end

  task automatic drive_start(input logic [31:0] d, input logic [4:0] s, input logic a);
    start_i = 1'b1;
    data_i  = d;
    shamt_i = s;
    arith_i = a;
  endtask

  // Called at a negedge of cycle 0; returns at the negedge of cycle 6.
  task automatic run_op(input logic [31:0] d, input logic [4:0] s, input logic a,
                        input logic [31:0] e);
    drive_start(d, s, a);
    exp_q.push_back(e);
    @(negedge clk_i);
    start_i = 1'b0;
    data_i  = $urandom;
    shamt_i = 5'($urandom);
    arith_i = 1'($urandom);
    for (int c = 1; c <= 5; c++) begin
      check("busy_ready", {31'b0, ready_o}, 32'd0);
      check("busy_valid", {31'b0, valid_o}, 32'd0);
      @(negedge clk_i);
    end
    check("done_valid", {31'b0, valid_o}, 32'd1);
    check("done_ready", {31'b0, ready_o}, 32'd1);
  endtask

  vec_t vecs [8];

  initial begin
    vecs[0] = '{32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001};
    vecs[1] = '{32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF};
    vecs[2] = '{32'h8000_0000, 5'd1,  1'b1, 32'hC000_0000};
    vecs[3] = '{32'hF000_0000, 5'd4,  1'b1, 32'hFF00_0000};
    vecs[4] = '{32'hF000_0000, 5'd4,  1'b0, 32'h0F00_0000};
    vecs[5] = '{32'h1234_5678, 5'd0,  1'b0, 32'h1234_5678};
    vecs[6] = '{32'h7FFF_FFFF, 5'd31, 1'b1, 32'h0000_0000};
    vecs[7] = '{32'h1234_5678, 5'd0,  1'b1, 32'h1234_5678};

    repeat (2) @(negedge clk_i);
    check("reset_ready", {31'b0, ready_o}, 32'd1);
    check("reset_valid", {31'b0, valid_o}, 32'd0);
    check("reset_data", data_o, 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    foreach (vecs[i]) begin
      run_op(vecs[i].data, vecs[i].shamt, vecs[i].arith, vecs[i].expected);
      @(negedge clk_i);
      check("idle_after_done", {31'b0, valid_o}, 32'd0);
    end

    // start_i during SHIFT (cycle 3) must be ignored
    drive_start(32'h8000_0000, 5'd31, 1'b0);
    exp_q.push_back(32'h0000_0001);
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    drive_start(32'hDEAD_BEEF, 5'd5, 1'b1);
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    check("ignored_start_valid", {31'b0, valid_o}, 32'd1);
    repeat (10) @(negedge clk_i);

    // back-to-back: new start in the DONE cycle
    run_op(32'h1234_5678, 5'd0, 1'b0, 32'h1234_5678);
    drive_start(32'h0000_FF00, 5'd8, 1'b0);
    exp_q.push_back(32'h0000_00FF);
    @(negedge clk_i);
    start_i = 1'b0;
    check("b2b_no_idle_ready", {31'b0, ready_o}, 32'd0);
    repeat (5) @(negedge clk_i);
    check("b2b_second_valid", {31'b0, valid_o}, 32'd1);
    @(negedge clk_i);

    // asynchronous reset during cycle 3 of SHIFT discards the operation
    drive_start(32'hF000_0000, 5'd4, 1'b1);
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    check("mid_reset_ready", {31'b0, ready_o}, 32'd1);
    check("mid_reset_valid", {31'b0, valid_o}, 32'd0);
    check("mid_reset_data", data_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (10) @(negedge clk_i);

    // random operands against the reference model
    for (int n = 0; n < 24; n++) begin
      logic [31:0] d;
      logic [4:0]  s;
      logic        a;
      d = $urandom;
      s = 5'($urandom_range(0, 31));
      a = 1'($urandom);
      run_op(d, s, a, model(d, s, a));
      if ($urandom_range(0, 1) == 1) @(negedge clk_i);
    end
    repeat (10) @(negedge clk_i);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sequential_shifter_right.md
# sequential_shifter_right

Multi-cycle right shifter for the RV32I execute stage, covering SRL/SRLI and SRA/SRAI. It applies one power-of-two stage per clock cycle, so a full shift takes a fixed number of cycles regardless of the shift amount. It replaces a wide single-cycle barrel shifter and is driven by the execute-stage controller through a start/ready/valid handshake.

## Interface
- nb_bits_data, 32, operand and result width; power of two, ≥ 2.
- nb_bits_shamt, $clog2(nb_bits_data), shift-amount width; also the number of shift stages (5 for 32 bits).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  request; accepted only when ready_o = 1.
- data_i  in  nb_bits_data  operand; sampled on acceptance.
- shamt_i  in  nb_bits_shamt  shift amount; sampled on acceptance.
- arith_i  in  1  fill select, sampled on acceptance: 1 = arithmetic (sign fill), 0 = logical (zero fill).
- ready_o  out  1  high in IDLE and DONE.
- valid_o  out  1  one-cycle pulse marking a new result.
- data_o  out  nb_bits_data  result register; holds its value until the next result or reset.

## Operation
- Three-state FSM:
  - IDLE: on start_i, latch data_i, shamt_i and arith_i; clear stage counter; go to SHIFT.
  - SHIFT: at stage k = 0 … nb_bits_shamt-1, shift the working register right by 2^k when shamt bit k = 1, otherwise pass it through. The counter increments each cycle. After stage nb_bits_shamt-1, load data_o and go to DONE.
  - DONE: valid_o = 1. With start_i, latch the new operands and go to SHIFT. Without start_i, go to IDLE.
- Fill rules:
  - Logical shift inserts zeros.
  - Arithmetic shift replicates the latched operand MSB. Each stage inherits the sign from the working register, whose MSB is never altered by an arithmetic stage.
- shamt = 0 still runs every stage and returns the operand unchanged. The latency is fixed.
- start_i in SHIFT is ignored and the in-flight operation is not disturbed.
- Input changes after acceptance have no effect.
- Shift amounts beyond nb_bits_data-1 cannot be expressed, because shamt_i is exactly nb_bits_shamt wide.

## Timing
- Reset values: state IDLE, ready_o = 1, valid_o = 0, data_o = 0, working register = 0, counter = 0.
- Reset asserted in any state, including mid-SHIFT, takes effect immediately. The in-flight result is discarded and never reported.
- Latency: start_i accepted in cycle 0 → SHIFT in cycles 1 … nb_bits_shamt → valid_o high in cycle nb_bits_shamt+1.
  - For 32 bits, valid_o is high in cycle 6.
  - data_o is valid in the same cycle valid_o rises.
- Throughput: a start accepted in the DONE cycle gives back-to-back operations, one result every nb_bits_shamt+1 cycles.
- ready_o is 0 for exactly nb_bits_shamt cycles per operation.
- valid_o is never high for two consecutive cycles.

## Structure
- Package shifter_pkg holds:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} shift_state_t;
  - localparam SHIFT_LOGICAL = 1'b0 and SHIFT_ARITH = 1'b1.
- Sub-module fixed_shifter_right:
  - Combinational, with parameters nb_bits_data and shift_value.
  - Ports: data_i, enable_i, arith_i, data_o.
  - The bypass is a configurable_mux.
- The block instantiates one fixed_shifter_right per stage (shift_value = 2^k) in a generate loop. A counter-indexed mux selects the stage output for the current cycle.
- One shared working register holds the value between stages.

## Test plan
- SRL, data 0x80000000, shamt 31 → data_o 0x00000001, valid_o high in cycle 6 only, ready_o low in cycles 1–5.
- SRA, data 0x80000000, shamt 31 → 0xFFFFFFFF. Same operand with shamt 1 → 0xC0000000.
- Data 0xF0000000, shamt 4: SRA → 0xFF000000, SRL → 0x0F000000. Data 0x12345678, shamt 0 → 0x12345678, still in cycle 6.
- Pulse start_i again in cycle 3 with different operands → ignored; the first result is unchanged.
- Assert start_i in the DONE cycle with 0x0000FF00 >> 8 → second valid_o 6 cycles later with 0x000000FF. No IDLE cycle between the two operations.
- Assert rst_i asynchronously during cycle 3 of SHIFT → immediately ready_o = 1, valid_o = 0, data_o = 0. No stale valid_o follows reset release.
